// File: rtl/neo_pbus_sched.sv
// P-bus slot scheduler: multiplexes sprite (C ROM) and fix (S ROM) addresses onto
// the shared 20-bit PBUS in a fixed 8-cycle slot and drives the PCK1B/PCK2B latch strobes.
module neo_pbus_sched #(
    parameter int MISS_W = 8
) (
    input  logic              CLK_24M,
    input  logic              RESET,
    input  logic              EN,
    input  logic              SPR_VALID,
    input  logic [19:0]       SPR_ADDR,
    output logic              SPR_READY,
    input  logic              FIX_VALID,
    input  logic [15:0]       FIX_ADDR,
    input  logic              FIX_H1,
    output logic              FIX_READY,
    output logic [19:0]       PBUS,
    output logic              PCK1B,
    output logic              PCK2B,
    output logic              S2H1,
    output logic [2:0]        PHASE,
    output logic              SPR_DONE,
    output logic              FIX_DONE,
    output logic [MISS_W-1:0] SPR_MISS
);

    logic [2:0]        r_phase;
    logic              r_spr_full;
    logic [19:0]       r_spr_addr;
    logic              r_fix_full;
    logic [15:0]       r_fix_addr;
    logic              r_fix_h1;
    logic              r_spr_act;
    logic              r_fix_act;
    logic [19:0]       r_pbus;
    logic              r_pck1b;
    logic              r_pck2b;
    logic              r_s2h1;
    logic              r_spr_done;
    logic              r_fix_done;
    logic [MISS_W-1:0] r_spr_miss;

    logic              w_spr_ready;
    logic              w_fix_ready;
    logic              w_slot_start;
    logic              w_fix_slot;

    // READY is held low during reset so nothing lands in a buffer that is being cleared.
    assign w_spr_ready  = ~r_spr_full & ~RESET;
    assign w_fix_ready  = ~r_fix_full & ~RESET;
    assign w_slot_start = (r_phase == 3'd0) & EN;
    assign w_fix_slot   = (r_phase == 3'd4);

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            r_phase    <= 3'd0;
            r_spr_full <= 1'b0;
            r_fix_full <= 1'b0;
            r_spr_act  <= 1'b0;
            r_fix_act  <= 1'b0;
            r_pbus     <= 20'd0;
            r_pck1b    <= 1'b0;
            r_pck2b    <= 1'b0;
            r_s2h1     <= 1'b0;
            r_spr_done <= 1'b0;
            r_fix_done <= 1'b0;
            r_spr_miss <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every decision below sees pre-edge state.
            if (r_phase != 3'd0 || EN)
                r_phase <= r_phase + 3'd1;

            // NOTE: entry data is deliberately not reset; the full flag alone marks it valid.
            if (SPR_VALID && w_spr_ready) begin
                r_spr_full <= 1'b1;
                r_spr_addr <= SPR_ADDR;
            end
            if (FIX_VALID && w_fix_ready) begin
                r_fix_full <= 1'b1;
                r_fix_addr <= FIX_ADDR;
                r_fix_h1   <= FIX_H1;
            end

            // Accept requires empty and grant requires full, so they never hit one entry together.
            if (w_slot_start) begin
                if (r_spr_full) begin
                    r_pbus     <= r_spr_addr;
                    r_spr_full <= 1'b0;
                    r_spr_act  <= 1'b1;
                end else begin
                    r_spr_act <= 1'b0;
                    if (r_spr_miss != '1)
                        r_spr_miss <= r_spr_miss + MISS_W'(1);
                end
            end

            if (w_fix_slot) begin
                if (r_fix_full) begin
                    r_pbus     <= {4'h0, r_fix_addr};
                    r_s2h1     <= r_fix_h1;
                    r_fix_full <= 1'b0;
                    r_fix_act  <= 1'b1;
                end else begin
                    r_fix_act <= 1'b0;
                end
            end

            // Strobes are registered one phase early so they appear during phases 2/3 and 6/7.
            r_pck1b    <= (r_phase == 3'd1) & r_spr_act;
            r_spr_done <= (r_phase == 3'd2) & r_spr_act;
            r_pck2b    <= (r_phase == 3'd5) & r_fix_act;
            r_fix_done <= (r_phase == 3'd6) & r_fix_act;
        end
    end

    assign SPR_READY = w_spr_ready;
    assign FIX_READY = w_fix_ready;
    assign PBUS      = r_pbus;
    assign PCK1B     = r_pck1b;
    assign PCK2B     = r_pck2b;
    assign S2H1      = r_s2h1;
    assign PHASE     = r_phase;
    assign SPR_DONE  = r_spr_done;
    assign FIX_DONE  = r_fix_done;
    assign SPR_MISS  = r_spr_miss;

endmodule

// File: tb/tb_neo_pbus_sched.sv
// Self-checking bench for neo_pbus_sched: directed scenarios plus random traffic,
// compared every cycle against a queue-based slot model.
module tb_neo_pbus_sched;

    localparam int MISS_W   = 8;
    localparam int MISS_MAX = (1 << MISS_W) - 1;

    typedef struct packed {
        logic [15:0] addr;
        logic        h1;
    } fix_req_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              spr_valid;
    logic [19:0]       spr_addr;
    logic              spr_ready;
    logic              fix_valid;
    logic [15:0]       fix_addr;
    logic              fix_h1;
    logic              fix_ready;
    logic [19:0]       pbus;
    logic              pck1b;
    logic              pck2b;
    logic              s2h1;
    logic [2:0]        phase;
    logic              spr_done;
    logic              fix_done;
    logic [MISS_W-1:0] spr_miss;

    neo_pbus_sched #(.MISS_W(MISS_W)) dut (
        .CLK_24M  (clk),
        .RESET    (rst),
        .EN       (en),
        .SPR_VALID(spr_valid),
        .SPR_ADDR (spr_addr),
        .SPR_READY(spr_ready),
        .FIX_VALID(fix_valid),
        .FIX_ADDR (fix_addr),
        .FIX_H1   (fix_h1),
        .FIX_READY(fix_ready),
        .PBUS     (pbus),
        .PCK1B    (pck1b),
        .PCK2B    (pck2b),
        .S2H1     (s2h1),
        .PHASE    (phase),
        .SPR_DONE (spr_done),
        .FIX_DONE (fix_done),
        .SPR_MISS (spr_miss)
    );

    always #5 clk = ~clk;

    // Reference model: slot position, one-deep request queues, last bus value, per-slot grant flags.
    logic [19:0] spr_q[$];
    fix_req_t    fix_q[$];
    int          m_phase;
    int          m_miss;
    logic [19:0] m_pbus;
    logic        m_s2h1;
    bit          m_spr_g;
    bit          m_fix_g;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [37:0] dut_vec();
        return {phase, pbus, pck1b, pck2b, s2h1, spr_done, fix_done, spr_ready, fix_ready, spr_miss};
    endfunction

    function automatic logic [37:0] exp_vec();
        logic [2:0] ph;
        ph = 3'(m_phase);
        return {ph, m_pbus,
                (m_phase == 2) && m_spr_g, (m_phase == 6) && m_fix_g, m_s2h1,
                (m_phase == 3) && m_spr_g, (m_phase == 7) && m_fix_g,
                (spr_q.size() == 0) && !rst, (fix_q.size() == 0) && !rst,
                MISS_W'(m_miss)};
    endfunction

    task automatic model_edge();
        bit       acc_s;
        bit       acc_f;
        fix_req_t fr;
        if (rst) begin
            spr_q.delete();
            fix_q.delete();
            m_phase = 0;
            m_miss  = 0;
            m_pbus  = '0;
            m_s2h1  = 1'b0;
            m_spr_g = 1'b0;
            m_fix_g = 1'b0;
        end else begin
            acc_s = spr_valid && (spr_q.size() == 0);
            acc_f = fix_valid && (fix_q.size() == 0);
            if (m_phase == 0) begin
                if (en) begin
                    if (spr_q.size() > 0) begin
                        m_pbus  = spr_q.pop_front();
                        m_spr_g = 1'b1;
                    end else begin
                        m_spr_g = 1'b0;
                        if (m_miss < MISS_MAX) m_miss++;
                    end
                    m_phase = 1;
                end
            end else begin
                if (m_phase == 4) begin
                    if (fix_q.size() > 0) begin
                        fr      = fix_q.pop_front();
                        m_pbus  = {4'h0, fr.addr};
                        m_s2h1  = fr.h1;
                        m_fix_g = 1'b1;
                    end else begin
                        m_fix_g = 1'b0;
                    end
                end
                m_phase = (m_phase + 1) % 8;
            end
            // Requests accepted at this edge join the queue after the grant decision.
            if (acc_s) spr_q.push_back(spr_addr);
            if (acc_f) fix_q.push_back(fix_req_t'{addr: fix_addr, h1: fix_h1});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic align(input int p);
        for (int i = 0; i < 16 && m_phase != p; i++) tick();
        n_checks++;
        if (phase !== 3'(p)) begin
            n_fail++;
            $display("FAIL align: PHASE=%0d wanted=%0d", phase, p);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; spr_valid = 1'b0; fix_valid = 1'b0;
        spr_addr = '0; fix_addr = '0; fix_h1 = 1'b0;
        tick();
        tick();
        n_checks++;
        if (dut_vec() !== 38'h0) begin
            n_fail++;
            $display("FAIL reset_state: dut=%h exp=%h", dut_vec(), 38'h0);
        end
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_model: dut=%h exp=%h", dut_vec(), exp_vec());
        end
        rst = 1'b0;
        en  = 1'b1;
        #1;
        n_checks++;
        if ({spr_ready, fix_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL ready_after_reset: got=%b exp=11", {spr_ready, fix_ready});
        end
    endtask

    task automatic test_idle_miss();
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec() || phase !== 3'((c + 1) % 8) || pck1b || pck2b) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: dut=%h exp=%h", c, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (spr_miss !== 8'd1) begin
            n_fail++;
            $display("FAIL miss_first_slot: got=%0d exp=1", spr_miss);
        end
        for (int c = 0; c < 299 * 8; c++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_run: dut=%h exp=%h", dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (spr_miss !== 8'd255) begin
            n_fail++;
            $display("FAIL miss_saturate: got=%0d exp=255", spr_miss);
        end
    endtask

    task automatic test_sprite();
        align(7);
        spr_valid = 1'b1;
        spr_addr  = 20'hABCDE;
        tick();
        spr_valid = 1'b0;
        spr_addr  = 20'h13579;
        n_checks++;
        if (spr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL spr_ready_full: got=%b exp=0", spr_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec() || pbus !== 20'hABCDE || pck1b !== (k == 2) ||
                spr_done !== (k == 3) || spr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL sprite_phase%0d: dut=%h exp=%h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_fix();
        align(3);
        fix_valid = 1'b1;
        fix_addr  = 16'h1234;
        fix_h1    = 1'b1;
        tick();
        fix_valid = 1'b0;
        fix_h1    = 1'b0;
        for (int k = 5; k <= 7; k++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec() || pbus !== 20'h01234 || s2h1 !== 1'b1 ||
                pck2b !== (k == 6) || fix_done !== (k == 7)) begin
                n_fail++;
                $display("FAIL fix_phase%0d: dut=%h exp=%h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] got[$];
        bit          acc;
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        spr_valid = 1'b1;
        spr_addr  = 20'h00001;
        for (int i = 0; i < 40 && got.size() < 3; i++) begin
            acc = spr_valid && (spr_q.size() == 0);
            tick();
            if (i == 0) en = 1'b1;
            if (acc) begin
                n_checks++;
                if (spr_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_ready_low: got=%b exp=0", spr_ready);
                end
                spr_addr = spr_addr + 20'd1;
                if (spr_addr > 20'd3) spr_valid = 1'b0;
            end
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: dut=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (pck1b === 1'b1) got.push_back(pbus);
        end
        n_checks++;
        if (got.size() != 3 || got[0] !== 20'd1 || got[1] !== 20'd2 || got[2] !== 20'd3) begin
            n_fail++;
            $display("FAIL b2b_order: got=%p exp=1,2,3", got);
        end
        n_checks++;
        if (spr_miss !== 8'd0) begin
            n_fail++;
            $display("FAIL b2b_no_miss: got=%0d exp=0", spr_miss);
        end
    endtask

    task automatic test_en_drop();
        bit saw_pck2b;
        saw_pck2b = 1'b0;
        align(2);
        fix_valid = 1'b1;
        fix_addr  = 16'hBEEF;
        fix_h1    = 1'b0;
        tick();
        fix_valid = 1'b0;
        en        = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pck2b === 1'b1) saw_pck2b = 1'b1;
            n_checks++;
            if (dut_vec() !== exp_vec() ||
                (i >= 4 && (phase !== 3'd0 || pck1b || pck2b || spr_done || fix_done))) begin
                n_fail++;
                $display("FAIL en_drop_cycle%0d: dut=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (!saw_pck2b) begin
            n_fail++;
            $display("FAIL en_drop_fix_completes: pck2b_seen=0 exp=1");
        end
        en = 1'b1;
        tick();
        n_checks++;
        if (phase !== 3'd1 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL en_resume: PHASE=%0d exp=1 dut=%h exp_vec=%h", phase, dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_slot();
        bit          bad;
        logic [19:0] a;
        a = 20'($urandom) | 20'h1;
        align(7);
        spr_valid = 1'b1;
        spr_addr  = a;
        fix_valid = 1'b1;
        fix_addr  = 16'h5A5A;
        fix_h1    = 1'b1;
        tick();
        spr_valid = 1'b0;
        fix_valid = 1'b0;
        tick();
        n_checks++;
        if (phase !== 3'd1 || pbus !== a) begin
            n_fail++;
            $display("FAIL rst_mid_grant: PHASE=%0d PBUS=%h exp 1/%h", phase, pbus, a);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (dut_vec() !== 38'h0 || dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: dut=%h exp=%h", dut_vec(), 38'h0);
        end
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (pck1b || pck2b || pbus !== 20'h0 || dut_vec() !== exp_vec()) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL rst_mid_dropped: dut=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            spr_valid = ($urandom_range(0, 3) != 0);
            spr_addr  = 20'($urandom);
            fix_valid = ($urandom_range(0, 2) != 0);
            fix_addr  = 16'($urandom);
            fix_h1    = 1'($urandom);
            en        = ($urandom_range(0, 19) != 0);
            rst       = ($urandom_range(0, 399) == 0);
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: dut=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
        rst = 1'b0;
        spr_valid = 1'b0;
        fix_valid = 1'b0;
    endtask

    initial begin
        m_phase = 0; m_miss = 0; m_pbus = '0; m_s2h1 = 1'b0;
        m_spr_g = 1'b0; m_fix_g = 1'b0;
        test_reset();
        test_idle_miss();
        test_sprite();
        test_fix();
        test_back_to_back();
        test_en_drop();
        test_reset_mid_slot();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule
